// File: rtl/regfile_wb_arbiter_if.sv
// Write-back handshake bundle: ALU and load result
// channels in, register file write port out.
interface regfile_wb_arbiter_if #(
  parameter int n = 32,
  parameter int r = 5
);
  logic         alu_valid;
  logic         alu_ready;
  logic [r-1:0] alu_wa;
  logic [n-1:0] alu_wd;
  logic         mem_valid;
  logic         mem_ready;
  logic [r-1:0] mem_wa;
  logic [n-1:0] mem_wd;
  logic         we3;
  logic [r-1:0] wa3;
  logic [n-1:0] wd3;

  modport master (
    output alu_valid, alu_wa, alu_wd,
    output mem_valid, mem_wa, mem_wd,
    input  alu_ready, mem_ready,
    input  we3, wa3, wd3
  );

  modport slave (
    input  alu_valid, alu_wa, alu_wd,
    input  mem_valid, mem_wa, mem_wd,
    output alu_ready, mem_ready,
    output we3, wa3, wd3
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register file write-back arbiter: in-order write queue
// draining one write per cycle. REGFILE_WB_FWD_EN adds q_ra lookup.
module regfile_wb_arbiter #(
  parameter int n     = 32,
  parameter int r     = 5,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  regfile_wb_arbiter_if.slave        bus,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  input  logic [r-1:0]               q_ra,
  output logic                       q_hit,
  output logic [n-1:0]               q_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [r-1:0]  wa_q [DEPTH];
  logic [n-1:0]  wd_q [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          mem_fire;
  logic          alu_fire;
  logic          push;
  logic          pop;
  logic [r-1:0]  in_wa;
  logic [n-1:0]  in_wd;

  // Fixed priority: loads win; readiness only from registered full
  always_comb begin
    full          = (count == FULL_CNT);
    bus.mem_ready = !full;
    bus.alu_ready = !full && !bus.mem_valid;
    mem_fire      = bus.mem_valid && bus.mem_ready;
    alu_fire      = bus.alu_valid && bus.alu_ready;
    in_wa         = mem_fire ? bus.mem_wa : bus.alu_wa;
    in_wd         = mem_fire ? bus.mem_wd : bus.alu_wd;
    push          = (mem_fire || alu_fire) && (in_wa != '0);
    pop           = (count != '0);
    bus.we3       = pop;
    bus.wa3       = pop ? wa_q[rd_ptr] : '0;
    bus.wd3       = pop ? wd_q[rd_ptr] : '0;
  end

  // Queue pointers and occupancy; the register file never stalls a pop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry payload storage; validity lives in pointers/count
  always_ff @(posedge clk) begin
    if (push) begin
      wa_q[wr_ptr] <= in_wa;
      wd_q[wr_ptr] <= in_wd;
    end
  end

`ifdef REGFILE_WB_FWD_EN
  logic [DEPTH-1:0] vld;

  // Per-entry valid bits so the lookup sees only queued writes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
    end else begin
      if (pop)  vld[rd_ptr] <= 1'b0;
      if (push) vld[wr_ptr] <= 1'b1;
    end
  end

  // Scan oldest to youngest so the youngest match wins
  always_comb begin
    logic [AW-1:0] idx;
    idx    = '0;
    q_hit  = 1'b0;
    q_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      if (vld[idx] && (wa_q[idx] == q_ra) && (q_ra != '0)) begin
        q_hit  = 1'b1;
        q_data = wd_q[idx];
      end
    end
  end
`else
  logic unused_q_ra;

  // Lookup disabled: outputs tied off, address ignored
  always_comb begin
    unused_q_ra = ^q_ra;
    q_hit       = 1'b0;
    q_data      = '0;
  end
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter.
// Lookup checks follow REGFILE_WB_FWD_EN.
module tb_regfile_wb_arbiter;
  logic        clk;
  logic        rst_n;
  logic [2:0]  count;
  logic        full;
  logic [4:0]  q_ra;
  logic        q_hit;
  logic [31:0] q_data;
  int          n_cmp;
  int          n_bad;

  regfile_wb_arbiter_if #(.n(32), .r(5)) bus ();

  regfile_wb_arbiter #(.n(32), .r(5), .DEPTH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .count  (count),
    .full   (full),
    .q_ra   (q_ra),
    .q_hit  (q_hit),
    .q_data (q_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0;
    bus.alu_wa    = '0;
    bus.alu_wd    = '0;
    bus.mem_valid = 1'b0;
    bus.mem_wa    = '0;
    bus.mem_wd    = '0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.mem_valid = 1'b1;
    bus.mem_wa    = 5'd9;
    bus.mem_wd    = 32'h1234;
    step();
    step();
    n_cmp++;
    if (bus.we3 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_we3 got %b want 0", bus.we3);
    end
    n_cmp++;
    if (count !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_count got %0d want 0", count);
    end
    n_cmp++;
    if (bus.mem_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mem_ready got %b want 1", bus.mem_ready);
    end
    n_cmp++;
    if ({full, q_hit, q_data, bus.wa3, bus.wd3} !== '0) begin
      n_bad++;
      $display("FAIL reset_outs got %b/%b/%h/%0d/%h want zeros",
               full, q_hit, q_data, bus.wa3, bus.wd3);
    end
    idle();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_alu();
    bus.alu_valid = 1'b1;
    bus.alu_wa    = 5'd5;
    bus.alu_wd    = 32'hDEADBEEF;
    #1;
    n_cmp++;
    if (bus.alu_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL single_ready got %b want 1", bus.alu_ready);
    end
    step();
    idle();
    n_cmp++;
    if ({bus.we3, bus.wa3, bus.wd3} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      n_bad++;
      $display("FAIL single_write got %b/%0d/%h want 1/5/deadbeef",
               bus.we3, bus.wa3, bus.wd3);
    end
    n_cmp++;
    if (count !== 3'd1) begin
      n_bad++;
      $display("FAIL single_count1 got %0d want 1", count);
    end
    step();
    n_cmp++;
    if ({count, bus.we3, bus.wa3, bus.wd3} !== '0) begin
      n_bad++;
      $display("FAIL single_drained got %0d/%b/%0d/%h want 0/0/0/0",
               count, bus.we3, bus.wa3, bus.wd3);
    end
  endtask

  task automatic test_contention();
    bus.mem_valid = 1'b1;
    bus.mem_wa    = 5'd3;
    bus.mem_wd    = 32'h11;
    bus.alu_valid = 1'b1;
    bus.alu_wa    = 5'd4;
    bus.alu_wd    = 32'h22;
    #1;
    n_cmp++;
    if ({bus.alu_ready, bus.mem_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL cont_ready got alu=%b mem=%b want 0/1",
               bus.alu_ready, bus.mem_ready);
    end
    step();
    bus.mem_valid = 1'b0;
    #1;
    n_cmp++;
    if ({bus.we3, bus.wa3, bus.wd3} !== {1'b1, 5'd3, 32'h11}) begin
      n_bad++;
      $display("FAIL cont_first got %b/%0d/%h want 1/3/11",
               bus.we3, bus.wa3, bus.wd3);
    end
    n_cmp++;
    if (bus.alu_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL cont_alu_ready got %b want 1", bus.alu_ready);
    end
    step();
    idle();
    n_cmp++;
    if ({bus.we3, bus.wa3, bus.wd3} !== {1'b1, 5'd4, 32'h22}) begin
      n_bad++;
      $display("FAIL cont_second got %b/%0d/%h want 1/4/22",
               bus.we3, bus.wa3, bus.wd3);
    end
    step();
    n_cmp++;
    if (bus.we3 !== 1'b0) begin
      n_bad++;
      $display("FAIL cont_end got %b want 0", bus.we3);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      bus.mem_valid = 1'b1;
      bus.mem_wa    = 5'(8 + i);
      bus.mem_wd    = 32'h100 + 32'(i);
      #1;
      n_cmp++;
      if ({bus.mem_ready, full} !== 2'b10) begin
        n_bad++;
        $display("FAIL b2b_ready[%0d] got rdy=%b full=%b want 1/0",
                 i, bus.mem_ready, full);
      end
      if (i > 0) begin
        n_cmp++;
        if ({bus.we3, bus.wa3, bus.wd3} !==
            {1'b1, 5'(7 + i), 32'h100 + 32'(i - 1)}) begin
          n_bad++;
          $display("FAIL b2b_order[%0d] got %b/%0d/%h want 1/%0d/%h",
                   i, bus.we3, bus.wa3, bus.wd3, 7 + i, 32'h100 + i - 1);
        end
      end
      step();
    end
    idle();
    n_cmp++;
    if ({bus.we3, bus.wa3, bus.wd3, count} !==
        {1'b1, 5'd12, 32'h104, 3'd1}) begin
      n_bad++;
      $display("FAIL b2b_last got %b/%0d/%h cnt=%0d want 1/12/104 cnt=1",
               bus.we3, bus.wa3, bus.wd3, count);
    end
    step();
    n_cmp++;
    if (count !== 3'd0) begin
      n_bad++;
      $display("FAIL b2b_drain got %0d want 0", count);
    end
  endtask

  task automatic test_x0();
    bus.mem_valid = 1'b1;
    bus.mem_wa    = 5'd0;
    bus.mem_wd    = 32'hFFFFFFFF;
    #1;
    n_cmp++;
    if (bus.mem_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL x0_ready got %b want 1", bus.mem_ready);
    end
    step();
    idle();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({count, bus.we3} !== 4'd0) begin
        n_bad++;
        $display("FAIL x0_dropped[%0d] got cnt=%0d we3=%b want 0/0",
                 i, count, bus.we3);
      end
      step();
    end
  endtask

  task automatic test_fwd();
    logic        exp_hit;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
`ifdef REGFILE_WB_FWD_EN
    exp_hit = 1'b1;
    exp_a   = 32'hA;
    exp_b   = 32'hB;
`else
    exp_hit = 1'b0;
    exp_a   = 32'h0;
    exp_b   = 32'h0;
`endif
    q_ra          = 5'd7;
    bus.alu_valid = 1'b1;
    bus.alu_wa    = 5'd7;
    bus.alu_wd    = 32'hA;
    step();
    bus.alu_wd = 32'hB;
    #1;
    n_cmp++;
    if ({q_hit, q_data} !== {exp_hit, exp_a}) begin
      n_bad++;
      $display("FAIL fwd_a got %b/%h want %b/%h", q_hit, q_data, exp_hit, exp_a);
    end
    step();
    idle();
    n_cmp++;
    if ({q_hit, q_data} !== {exp_hit, exp_b}) begin
      n_bad++;
      $display("FAIL fwd_b got %b/%h want %b/%h", q_hit, q_data, exp_hit, exp_b);
    end
    q_ra = 5'd0;
    #1;
    n_cmp++;
    if ({q_hit, q_data} !== 33'd0) begin
      n_bad++;
      $display("FAIL fwd_ra0 got %b/%h want 0/0", q_hit, q_data);
    end
    q_ra = 5'd7;
    step();
    n_cmp++;
    if ({q_hit, q_data, count} !== 36'd0) begin
      n_bad++;
      $display("FAIL fwd_empty got %b/%h cnt=%0d want 0/0/0",
               q_hit, q_data, count);
    end
    q_ra = 5'd0;
  endtask

  task automatic test_mid_reset();
    bus.mem_valid = 1'b1;
    bus.mem_wa    = 5'd6;
    bus.mem_wd    = 32'h66;
    step();
    idle();
    rst_n = 1'b0;
    step();
    n_cmp++;
    if ({count, bus.we3, bus.wa3, bus.wd3} !== '0) begin
      n_bad++;
      $display("FAIL midrst got cnt=%0d we3=%b %0d/%h want zeros",
               count, bus.we3, bus.wa3, bus.wd3);
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (bus.we3 !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_after got %b want 0", bus.we3);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    q_ra  = '0;
    rst_n = 1'b0;
    idle();
    #1;
    test_reset();
    test_single_alu();
    test_contention();
    test_back_to_back();
    test_x0();
    test_fwd();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
